// File: rtl/qclk_trig_pkg.sv
// qclk_trig_pkg: shared widths and trigger FSM state encoding
package qclk_trig_pkg;
  localparam int QCLK_W = 32;
  localparam int PULSE_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_e;
endpackage

// File: rtl/qclk_trig_if.sv
// qclk_trig_if: controller-side bundle of the qclk trigger block
interface qclk_trig_if;
  import qclk_trig_pkg::*;
  logic                    qclk_load_en;
  logic [QCLK_W-1:0]       qclk_load_val;
  logic                    qclk_rst;
  logic                    write_pulse_en;
  logic [PULSE_DATA_W-1:0] pulse_data_in;
  logic                    c_strobe_enable;
  logic [QCLK_W-1:0]       cmd_time;
  logic                    cstrobe_out;
  logic [PULSE_DATA_W-1:0] pulse_data_out;
  logic [QCLK_W-1:0]       qclk_val;
  logic                    armed;
  logic                    late_err;
  modport master (
    output qclk_load_en, qclk_load_val, qclk_rst, write_pulse_en, pulse_data_in,
           c_strobe_enable, cmd_time,
    input  cstrobe_out, pulse_data_out, qclk_val, armed, late_err
  );
  modport slave (
    input  qclk_load_en, qclk_load_val, qclk_rst, write_pulse_en, pulse_data_in,
           c_strobe_enable, cmd_time,
    output cstrobe_out, pulse_data_out, qclk_val, armed, late_err
  );
endinterface

// File: rtl/qclk_trig_counter.sv
// qclk_counter: free-running qclk with clear > load > increment priority
module qclk_counter
  import qclk_trig_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load_en,
  input  logic [QCLK_W-1:0] load_val,
  output logic [QCLK_W-1:0] val
);
  logic [QCLK_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : load_en ? load_val : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign val = cnt_q;
endmodule

// File: rtl/qclk_trig.sv
// qclk_trig: timed trigger strobe against qclk; QCLK_TRIG_LATE_ERR_EN enables late firing with sticky late_err
module qclk_trig
  import qclk_trig_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    qclk_load_en,
  input  logic [QCLK_W-1:0]       qclk_load_val,
  input  logic                    qclk_rst,
  input  logic                    write_pulse_en,
  input  logic [PULSE_DATA_W-1:0] pulse_data_in,
  input  logic                    c_strobe_enable,
  input  logic [QCLK_W-1:0]       cmd_time,
  output logic                    cstrobe_out,
  output logic [PULSE_DATA_W-1:0] pulse_data_out,
  output logic [QCLK_W-1:0]       qclk_val,
  output logic                    armed,
  output logic                    late_err
);
  state_e                  state_q, state_d;
  logic [QCLK_W-1:0]       trig_q, trig_d;
  logic [PULSE_DATA_W-1:0] stage_q, stage_d, pdo_q, pdo_d;
  logic                    late_q, late_d;
  logic                    match, late;
  qclk_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (qclk_rst),
    .load_en  (qclk_load_en),
    .load_val (qclk_load_val),
    .val      (qclk_val)
  );
  assign match = qclk_val == trig_q;
`ifdef QCLK_TRIG_LATE_ERR_EN
  logic [QCLK_W-1:0] diff;
  assign diff = trig_q - qclk_val;
  assign late = diff[QCLK_W-1];
`else
  assign late = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    stage_d = write_pulse_en ? pulse_data_in : stage_q;
    pdo_d   = pdo_q;
    late_d  = late_q;
    case (state_q)
      IDLE: if (c_strobe_enable) begin
        state_d = ARMED;
        trig_d  = cmd_time;
      end
      ARMED: if (!c_strobe_enable) state_d = IDLE;
      else if (match || late) begin
        state_d = FIRE;
        pdo_d   = stage_q;
        late_d  = late_q | (late & ~match);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      trig_q  <= '0;
      stage_q <= '0;
      pdo_q   <= '0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      stage_q <= stage_d;
      pdo_q   <= pdo_d;
      late_q  <= late_d;
    end
  end
  assign cstrobe_out    = state_q == FIRE;
  assign armed          = state_q == ARMED;
  assign pulse_data_out = pdo_q;
  assign late_err       = late_q;
endmodule

// File: tb/tb_qclk_trig.sv
// tb_qclk_trig: directed vectors with hand-computed expectations for qclk_trig
module tb_qclk_trig;
  import qclk_trig_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   strobe_cnt = 0;
  localparam logic [63:0] PD_A = 64'hA5A5_0000_0000_1234;
  localparam logic [63:0] PD_B = 64'h0000_DEAD_BEEF_0000;
  qclk_trig_if bus ();
  qclk_trig dut (
    .clk             (clk),
    .reset           (reset),
    .qclk_load_en    (bus.qclk_load_en),
    .qclk_load_val   (bus.qclk_load_val),
    .qclk_rst        (bus.qclk_rst),
    .write_pulse_en  (bus.write_pulse_en),
    .pulse_data_in   (bus.pulse_data_in),
    .c_strobe_enable (bus.c_strobe_enable),
    .cmd_time        (bus.cmd_time),
    .cstrobe_out     (bus.cstrobe_out),
    .pulse_data_out  (bus.pulse_data_out),
    .qclk_val        (bus.qclk_val),
    .armed           (bus.armed),
    .late_err        (bus.late_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.cstrobe_out) strobe_cnt++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic restart_qclk();
    bus.qclk_rst = 1'b1;
    cyc();
    bus.qclk_rst = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.qclk_load_en = 1'b0;
    bus.qclk_load_val = '0;
    bus.qclk_rst = 1'b0;
    bus.write_pulse_en = 1'b0;
    bus.pulse_data_in = '0;
    bus.c_strobe_enable = 1'b0;
    bus.cmd_time = '0;
    cyc();
    check("rst_qclk", 64'(bus.qclk_val), 64'd0);
    check("rst_strobe", 64'(bus.cstrobe_out), 64'd0);
    check("rst_armed", 64'(bus.armed), 64'd0);
    check("rst_pdo", bus.pulse_data_out, 64'd0);
    check("rst_late", 64'(bus.late_err), 64'd0);
    reset = 1'b0;
    cyc(10);
    check("free_qclk10", 64'(bus.qclk_val), 64'd10);
    check("free_no_strobe", 64'(strobe_cnt), 64'd0);
    bus.write_pulse_en = 1'b1;
    bus.pulse_data_in = PD_A;
    cyc();
    bus.write_pulse_en = 1'b0;
    cyc(9);
    check("arm_at_qclk", 64'(bus.qclk_val), 64'd20);
    bus.c_strobe_enable = 1'b1;
    bus.cmd_time = 32'd50;
    cyc();
    check("armed_state", 64'(bus.armed), 64'd1);
    cyc(29);
    check("match_cycle_no_strobe", 64'(bus.cstrobe_out), 64'd0);
    bus.write_pulse_en = 1'b1;
    bus.pulse_data_in = PD_B;
    cyc();
    check("fire_strobe", 64'(bus.cstrobe_out), 64'd1);
    check("fire_qclk", 64'(bus.qclk_val), 64'd51);
    check("fire_pdo_old_stage", bus.pulse_data_out, PD_A);
    bus.c_strobe_enable = 1'b0;
    bus.write_pulse_en = 1'b0;
    cyc();
    check("fire_one_cycle", 64'(bus.cstrobe_out), 64'd0);
    check("fire_back_idle", 64'(bus.armed), 64'd0);
    check("pdo_hold", bus.pulse_data_out, PD_A);
    check("strobe_single", 64'(strobe_cnt), 64'd1);
    restart_qclk();
    check("qclk_rst_zero", 64'(bus.qclk_val), 64'd0);
    cyc(30);
    bus.c_strobe_enable = 1'b1;
    bus.cmd_time = 32'd100;
    cyc(10);
    bus.qclk_load_en = 1'b1;
    bus.qclk_load_val = 32'd99;
    cyc();
    bus.qclk_load_en = 1'b0;
    check("load_no_inc", 64'(bus.qclk_val), 64'd99);
    check("load_still_armed", 64'(bus.armed), 64'd1);
    cyc();
    check("load_no_early", 64'(bus.cstrobe_out), 64'd0);
    check("load_no_early_cnt", 64'(strobe_cnt), 64'd1);
    cyc();
    check("load_fire", 64'(bus.cstrobe_out), 64'd1);
    bus.c_strobe_enable = 1'b0;
    cyc();
    check("load_strobe_cnt", 64'(strobe_cnt), 64'd2);
    restart_qclk();
    cyc(20);
    bus.c_strobe_enable = 1'b1;
    bus.cmd_time = 32'd30;
    cyc(5);
    check("abort_qclk", 64'(bus.qclk_val), 64'd25);
    bus.c_strobe_enable = 1'b0;
    cyc();
    check("abort_idle", 64'(bus.armed), 64'd0);
    cyc(5);
    check("abort_no_strobe", 64'(bus.cstrobe_out), 64'd0);
    cyc();
    check("abort_strobe_cnt", 64'(strobe_cnt), 64'd2);
    restart_qclk();
    cyc(10);
    bus.c_strobe_enable = 1'b1;
    bus.cmd_time = 32'd5;
    cyc();
    check("late_armed", 64'(bus.armed), 64'd1);
    cyc();
`ifdef QCLK_TRIG_LATE_ERR_EN
    check("late_fire", 64'(bus.cstrobe_out), 64'd1);
    check("late_err_set", 64'(bus.late_err), 64'd1);
    check("late_pdo", bus.pulse_data_out, PD_B);
    bus.c_strobe_enable = 1'b0;
    cyc(3);
    check("late_err_sticky", 64'(bus.late_err), 64'd1);
`else
    check("late_no_fire", 64'(bus.cstrobe_out), 64'd0);
    check("late_err_tied", 64'(bus.late_err), 64'd0);
    bus.qclk_load_en = 1'b1;
    bus.qclk_load_val = 32'hFFFF_FFFE;
    cyc();
    bus.qclk_load_en = 1'b0;
    check("wrap_load", 64'(bus.qclk_val), 64'hFFFF_FFFE);
    cyc(2);
    check("wrap_zero", 64'(bus.qclk_val), 64'd0);
    cyc(5);
    check("wrap_no_early", 64'(bus.cstrobe_out), 64'd0);
    cyc();
    check("wrap_fire", 64'(bus.cstrobe_out), 64'd1);
    check("wrap_pdo", bus.pulse_data_out, PD_B);
    bus.c_strobe_enable = 1'b0;
    cyc();
`endif
    check("late_strobe_cnt", 64'(strobe_cnt), 64'd3);
    restart_qclk();
    cyc(10);
    bus.c_strobe_enable = 1'b1;
    bus.cmd_time = 32'd20;
    cyc(9);
    check("prereset_armed", 64'(bus.armed), 64'd1);
    reset = 1'b1;
    bus.c_strobe_enable = 1'b0;
    cyc();
    check("areset_qclk", 64'(bus.qclk_val), 64'd0);
    check("areset_strobe", 64'(bus.cstrobe_out), 64'd0);
    check("areset_armed", 64'(bus.armed), 64'd0);
    check("areset_pdo", bus.pulse_data_out, 64'd0);
    check("areset_late", 64'(bus.late_err), 64'd0);
    reset = 1'b0;
    cyc(25);
    check("areset_no_strobe", 64'(strobe_cnt), 64'd3);
    check("areset_qclk_run", 64'(bus.qclk_val), 64'd25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/qclk_trig.md
QCLK_TRIG -- requirements
Module: qclk_trig

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: qclk_load_en  input  1  load qclk from qclk_load_val (controller INC_QCLK path).
REQ-004 SHALL have ports: qclk_load_val  input  32  new qclk value (ALU result).
REQ-005 SHALL have ports: qclk_rst  input  1  restart qclk at 0 (sync release).
REQ-006 SHALL have ports: write_pulse_en  input  1  capture pulse_data_in into the staging register.
REQ-007 SHALL have ports: pulse_data_in  input  64  pulse parameters from command word.
REQ-008 SHALL have ports: c_strobe_enable  input  1  controller requests timed trigger; held high until cstrobe_out seen.
REQ-009 SHALL have ports: cmd_time  input  32  trigger time in qclk ticks, sampled on arm.
REQ-010 SHALL have ports: cstrobe_out  output  1  one-cycle trigger strobe, feeds controller cstrobe_in.
REQ-011 SHALL have ports: pulse_data_out  output  64  pulse parameters released to the pulse generator.
REQ-012 SHALL have ports: qclk_val  output  32  current qclk, feeds ALU in1 (QCLK select).
REQ-013 SHALL have ports: armed  output  1  high in ARMED state.
REQ-014 SHALL have ports: late_err  output  1  sticky late-trigger flag (see Configuration).

Function
REQ-015 qclk SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF -> 0.
REQ-016 qclk update priority SHALL be: qclk_rst (-> 0) > qclk_load_en (-> qclk_load_val, no increment that cycle) > increment.
REQ-017 Staging register SHALL load pulse_data_in on every cycle write_pulse_en is high.
REQ-018 FSM states SHALL be IDLE, ARMED, FIRE.
REQ-019 IDLE: c_strobe_enable high -> ARMED next cycle, trig_time <= cmd_time.
REQ-020 ARMED: c_strobe_enable low -> IDLE, no strobe (abort).
REQ-021 ARMED: qclk == trig_time -> FIRE next cycle.
REQ-022 FIRE SHALL last exactly one cycle, cstrobe_out = 1, then IDLE unconditionally (no re-arm in FIRE).
REQ-023 On ARMED->FIRE edge, pulse_data_out SHALL load the staging register value as of that edge (old value if write_pulse_en coincides).
REQ-024 Latency: qclk == trig_time in cycle N -> cstrobe_out high in cycle N+1.
REQ-025 qclk load/reset while ARMED: comparison SHALL use the updated qclk from the following cycle.
REQ-026 pulse_data_out SHALL hold its value until the next FIRE.

Reset
REQ-027 reset SHALL force: state IDLE, qclk 0, trig_time 0, staging 0, pulse_data_out 0, cstrobe_out 0, late_err 0.
REQ-028 reset asserted in ARMED or FIRE SHALL abort with no strobe in the following cycle.

Configuration
REQ-029 Macro QCLK_TRIG_LATE_ERR_EN defined: in ARMED, if signed 32-bit (trig_time - qclk) < 0, SHALL go to FIRE next cycle and set late_err (sticky until reset).
REQ-030 Macro undefined: exact equality only (late trigger fires after qclk wrap), late_err tied 0.

Structure
REQ-031 Shared package SHALL hold QCLK_W=32, PULSE_DATA_W=64, FSM state enum.
REQ-032 qclk counter SHALL be a separate sub-module qclk_counter (rst/load/increment, value out).

Verification
REQ-033 Reset, no inputs 10 cycles -> qclk_val=10 after 10 cycles, cstrobe_out never high.
REQ-034 write_pulse_en with data 0xA5A5_0000_0000_1234, arm with cmd_time=50 at qclk=20 -> cstrobe_out single pulse in cycle after qclk=50, pulse_data_out=0xA5A5_0000_0000_1234.
REQ-035 Armed for cmd_time=100, qclk_load_en val=99 at qclk=40 -> strobe one cycle after qclk reaches 100, no earlier.
REQ-036 Arm cmd_time=30, drop c_strobe_enable at qclk=25 -> state IDLE, no strobe at qclk=30.
REQ-037 Macro defined, arm cmd_time=5 at qclk=10 -> FIRE next cycle, late_err=1 and stays 1 until reset; macro undefined -> no strobe until qclk wraps to 5.
REQ-038 reset asserted in ARMED one cycle before match -> no strobe, all outputs 0, qclk_val=0.
